// File: rtl/alu_share_pkg.sv
// Shared types and opcode constants for the ALU sharing arbiter.
// Pure declarations, so this file has no latency and no backpressure.
package alu_share_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND = 4'b0000;
    localparam alu_op_t ALU_OR  = 4'b0001;
    localparam alu_op_t ALU_ADD = 4'b0010;
    localparam alu_op_t ALU_SUB = 4'b0110;
    localparam alu_op_t ALU_NOP = 4'b1111;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    function automatic logic op_is_legal(input alu_op_t op);
        return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Round-robin pick: the first requester after 'last', wrapping modulo N.
// Combinational, zero latency; with en low no grant is issued.
module rr_arbiter #(
    parameter int N    = 2,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    input  logic            en,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_idx
);

    logic            found;
    logic [ID_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = ID_W'((int'(last) + k) % N);
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ round-robin requesters; opcode checking under ALU_SHARE_OPCHECK_EN.
// Latency: accept at N, ALU driven at N+1, response valid from N+2; one op per 2 cycles at best.
// Backpressure: a held response (rsp_ready low) blocks every req_ready until it is consumed.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    input  logic [4*NUM_REQ-1:0]  req_op,
    output logic [31:0]           alu_data1,
    output logic [31:0]           alu_data2,
    output logic [3:0]            alu_control,
    input  logic [31:0]           alu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_result,
    output logic                  rsp_zero,
    output logic                  rsp_err
);

    state_t          state, state_nxt;
    logic [ID_W-1:0] rr_last, gnt_idx, id_q;
    logic [NUM_REQ-1:0] gnt;
    logic            acc, gnt_any;
    logic [31:0]     a_q, b_q, sel_a, sel_b, res_d;
    alu_op_t         op_q, sel_op;

    // Reset also blocks grants so req_ready is quiet while reset is held.
    assign acc = !reset && ((state == IDLE) || (state == RESP && rsp_ready));

    rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req       (req_valid),
        .last      (rr_last),
        .en        (acc),
        .grant     (gnt),
        .grant_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign gnt_any   = |gnt;
    assign rsp_valid = (state == RESP);
    assign rsp_id    = id_q;
    assign alu_data1 = (state == EXEC) ? a_q : '0;
    assign alu_data2 = (state == EXEC) ? b_q : '0;

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = ALU_NOP;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
                sel_op = req_op[4*i +: 4];
            end
        end
    end

`ifdef ALU_SHARE_OPCHECK_EN
    logic err_q, rsp_err_q;

    // Illegal ops still spend the EXEC cycle, but the ALU only ever sees NOP.
    assign alu_control = (state == EXEC && !err_q) ? op_q : ALU_NOP;
    assign res_d       = err_q ? '0 : alu_result;
    assign rsp_err     = rsp_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q     <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            if (gnt_any)
                err_q <= !op_is_legal(sel_op);
            if (state == EXEC)
                rsp_err_q <= err_q;
        end
    end
`else
    assign alu_control = (state == EXEC) ? op_q : ALU_NOP;
    assign res_d       = alu_result;
    assign rsp_err     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_any) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = gnt_any ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_last    <= ID_W'(NUM_REQ - 1);
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            id_q       <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (gnt_any) begin
                a_q     <= sel_a;
                b_q     <= sel_b;
                op_q    <= sel_op;
                id_q    <= gnt_idx;
                rr_last <= gnt_idx;
            end
            if (state == EXEC) begin
                rsp_result <= res_d;
                rsp_zero   <= (res_d == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: external ALU model, arbitration/latency model and response scoreboard.
module tb_alu_share_arbiter;
    import alu_share_pkg::*;

    localparam int N  = 2;
    localparam int IW = 1;
`ifdef ALU_SHARE_OPCHECK_EN
    localparam bit OPCHECK = 1'b1;
`else
    localparam bit OPCHECK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_ready;
    logic [32*N-1:0] req_a, req_b;
    logic [4*N-1:0]  req_op;
    logic [31:0]     alu_data1, alu_data2, alu_result, rsp_result;
    logic [3:0]      alu_control;
    logic            rsp_valid, rsp_ready, rsp_zero, rsp_err;
    logic [IW-1:0]   rsp_id;

    typedef struct {
        logic [IW-1:0] id;
        logic [31:0]   res;
        logic          zero;
        logic          err;
        int            acc_cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0, cyc = 0, rsp_cnt = 0;
    int   mlast = N - 1, acc_cyc = 0;
    bit   inflight = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU behaviour: logical AND/OR, wrapping ADD/SUB, anything else gives 0.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'b0000: return {31'b0, (a != 0) && (b != 0)};
            4'b0001: return {31'b0, (a != 0) || (b != 0)};
            4'b0010: return a + b;
            4'b0110: return a - b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit legal_op(input logic [3:0] op);
        return op == 4'b0000 || op == 4'b0001 || op == 4'b0010 || op == 4'b0110;
    endfunction

    assign alu_result = alu_fn(alu_data1, alu_data2, alu_control);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    alu_share_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_control(alu_control),
        .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    // Arbitration model: an op occupies the ALU until its response is taken, at least 2 cycles.
    always @(negedge clk) begin
        logic [N-1:0] eg;
        int   w, c;
        bit   can;
        exp_t e;
        if (reset) begin
            q.delete();
            inflight = 1'b0;
            mlast    = N - 1;
        end else begin
            can = !inflight || (cyc >= acc_cyc + 2 && rsp_ready);
            eg  = '0;
            w   = -1;
            if (can) begin
                for (int k = 1; k <= N; k++) begin
                    c = (mlast + k) % N;
                    if (w < 0 && req_valid[c]) w = c;
                end
            end
            if (w >= 0) eg[w] = 1'b1;
            chk("req_ready", req_ready, eg);
            if (inflight && cyc >= acc_cyc + 2 && rsp_ready) inflight = 1'b0;
            if (w >= 0) begin
                e.id      = IW'(w);
                e.res     = alu_fn(req_a[32*w +: 32], req_b[32*w +: 32], req_op[4*w +: 4]);
                e.zero    = (e.res == 0);
                e.err     = OPCHECK && !legal_op(req_op[4*w +: 4]);
                e.acc_cyc = cyc;
                q.push_back(e);
                inflight = 1'b1;
                acc_cyc  = cyc;
                mlast    = w;
            end
        end
    end

    // Response monitor: latency, hold stability while stalled, and scoreboard compare.
    logic          pv = 1'b0, pr = 1'b0, hz, he;
    logic [IW-1:0] hid;
    logic [31:0]   hres;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", rsp_valid, 1);
                chk("hold_id", rsp_id, hid);
                chk("hold_result", rsp_result, hres);
                chk("hold_zero", rsp_zero, hz);
                chk("hold_err", rsp_err, he);
            end else if (rsp_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 with no request outstanding (cycle %0d)", cyc);
                end else begin
                    chk("latency", cyc, q[0].acc_cyc + 2);
                end
            end
            if (rsp_valid && rsp_ready && q.size() > 0) begin
                e = q.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_result", rsp_result, e.res);
                chk("rsp_zero", rsp_zero, e.zero);
                chk("rsp_err", rsp_err, e.err);
                rsp_cnt++;
            end
            pv = rsp_valid; pr = rsp_ready;
            hid = rsp_id; hres = rsp_result; hz = rsp_zero; he = rsp_err;
        end
    end

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[4*i +: 4]  = op;
        req_valid[i]      = 1'b1;
    endtask

    // Returns at posedge+1 after the accepting edge, i.e. with the DUT in EXEC.
    task automatic send(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        bit ok;
        ok = 1'b0;
        set_req(i, a, b, op);
        for (int t = 0; t < 60 && !ok; t++) begin
            @(negedge clk);
            if (req_ready[i]) ok = 1'b1;
        end
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: requester %0d never saw req_ready", i);
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (q.size() == 0 && !inflight && !rsp_valid) done = 1'b1;
        end
        chk("drain", done, 1);
        @(posedge clk); #1;
    endtask

    function automatic logic [3:0] rand_op();
        logic [3:0] ops [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0101, 4'b1111, 4'b0011};
        return ops[$urandom_range(0, 6)];
    endfunction

    function automatic logic [31:0] rand_val();
        return ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom());
    endfunction

    initial begin
        logic [N-1:0] got;
        int snap;
        reset = 1'b1; req_valid = '1; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_control", alu_control, 4'hF);
        chk("rst_alu_data1", alu_data1, 0);
        chk("rst_alu_data2", alu_data2, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_result", rsp_result, 0);
        @(posedge clk); #1;
        req_valid = '0;
        reset = 1'b0;

        // ADD 5+3 from requester 0: ALU control is driven for exactly one cycle.
        send(0, 32'd5, 32'd3, 4'b0010);
        @(negedge clk);
        chk("exec_control", alu_control, 4'b0010);
        chk("exec_data1", alu_data1, 32'd5);
        chk("exec_data2", alu_data2, 32'd3);
        @(negedge clk);
        chk("resp_control", alu_control, 4'hF);
        chk("resp_data1", alu_data1, 0);
        wait_idle();

        // SUB giving zero, then SUB that wraps.
        send(1, 32'd7, 32'd7, 4'b0110);
        send(1, 32'd0, 32'd1, 4'b0110);
        wait_idle();

        // Both requesters continuously valid: one response every 2 cycles.
        set_req(0, rand_val(), rand_val(), rand_op());
        set_req(1, rand_val(), rand_val(), rand_op());
        snap = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            got = req_ready;
            @(posedge clk); #1;
            if (k == 3) snap = rsp_cnt;
            for (int i = 0; i < N; i++)
                if (got[i]) set_req(i, rand_val(), rand_val(), rand_op());
        end
        chk("throughput", rsp_cnt - snap, 8);
        req_valid = '0;
        wait_idle();

        // Stalled response: nothing granted until rsp_ready rises, then immediate accept.
        rsp_ready = 1'b0;
        send(0, 32'h1234, 32'h1, 4'b0010);
        set_req(1, 32'h10, 32'h20, 4'b0001);
        repeat (6) begin
            @(negedge clk);
            chk("stall_no_grant", req_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_grant", req_ready, 2'b10);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();

        // Reset while in EXEC drops the op; requester 0 then has first priority again.
        send(0, 32'd9, 32'd9, 4'b0010);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        set_req(0, 32'd1, 32'd2, 4'b0010);
        set_req(1, 32'd3, 32'd4, 4'b0010);
        @(negedge clk);
        chk("post_reset_prio", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();

        // Illegal opcode.
        send(0, 32'd9, 32'd4, 4'b0101);
        @(negedge clk);
        chk("illegal_control", alu_control, OPCHECK ? 4'hF : 4'b0101);
        wait_idle();

        // Randomized traffic with random backpressure and withdrawn requests.
        for (int t = 0; t < 800; t++) begin
            @(negedge clk);
            got = req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (got[i])
                    req_valid[i] = 1'b0;
                else if (req_valid[i] && $urandom_range(0, 15) == 0)
                    req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, rand_val(), rand_val(), rand_op());
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (32-bit operands, 4-bit control) between NUM_REQ requesters, such as the integer pipe, address generation and a debug port.
- Round-robin arbitration with a valid/ready handshake per requester.
- Operands are captured into registers and driven to the ALU for one cycle.
- The result is registered and presented on a single response channel tagged with the requester id.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ), width of the requester id.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_ready  out  NUM_REQ  request accepted this cycle; one-hot or zero.
- req_a  in  32*NUM_REQ  operand A, flattened; requester i occupies [32i+31:32i].
- req_b  in  32*NUM_REQ  operand B, flattened.
- req_op  in  4*NUM_REQ  ALU control code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
- alu_data1  out  32  to ALU data1.
- alu_data2  out  32  to ALU data2.
- alu_control  out  4  to ALU control.
- alu_result  in  32  from ALU result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_result  out  32  registered ALU result.
- rsp_zero  out  1  1 when rsp_result == 0; computed locally; the ALU Zero output is not used.
- rsp_err  out  1  illegal opcode flag; see Optional Feature.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset values:
  - state = IDLE; rr_last = NUM_REQ-1, so requester 0 wins first.
  - All operand, op, id and result registers = 0.
  - rsp_valid = 0, rsp_err = 0, req_ready = 0.
  - alu_control = 4'b1111, which drives a zero result.
- Accept condition: acc = (state==IDLE) | (state==RESP & rsp_ready).
- Grant: the first i with req_valid[i], searching from rr_last+1 upward modulo NUM_REQ.
  - req_ready[g] = acc & req_valid[g]; combinational, and no other bit is set.
- On accept: capture a, b, op and id of g into registers; rr_last <= g; state -> EXEC.
- IDLE: if no request is valid, stay in IDLE.
- EXEC:
  - alu_data1, alu_data2 and alu_control are driven from the capture registers, and only in EXEC.
  - Outside EXEC, alu_data1 and alu_data2 are 0 and alu_control is 1111.
  - At the end of EXEC, alu_result is registered into rsp_result and rsp_zero is computed; state -> RESP.
- RESP:
  - rsp_valid = 1; rsp_id, rsp_result, rsp_zero and rsp_err are held stable until rsp_ready.
  - rsp_ready with a new request pending: that request is accepted in the same cycle and the next state is EXEC.
  - rsp_ready with no request pending: state -> IDLE.
- Latency: accept at cycle N; ALU driven during cycle N+1; rsp_valid from cycle N+2.
- Throughput: one operation per 2 cycles when the consumer holds rsp_ready = 1.
- Requester rules: a requester holds req_valid and its payload stable until req_ready.
  - Deasserting req_valid before grant is allowed; the request is then not counted.
- Simultaneous requests: exactly one is granted per accept.
  - With continuous requests from all requesters, grants rotate 0, 1, ..., NUM_REQ-1, 0.
- rr_last updates only on a grant.
- Reset while in EXEC or RESP: the in-flight operation is dropped with no response; all state returns to reset values.
- Widths:
  - ADD and SUB wrap modulo 2^32; the block does no extension.
  - The ALU implements AND and OR as logical operators, giving 0 or 1. The block passes the result through unmodified.

Optional Feature:
- Macro: ALU_SHARE_OPCHECK_EN.
- Defined:
  - Any op outside {0000, 0001, 0010, 0110} still takes the EXEC cycle.
  - alu_control is forced to 1111 during that cycle.
  - The response carries rsp_result = 0, rsp_zero = 1, rsp_err = 1.
- Undefined: rsp_err is tied to 0, ops pass to the ALU unchanged, and an illegal op returns the ALU default result of 0.

Decomposition:
- Package alu_share_pkg holds:
  - typedef alu_op_t, 4 bits;
  - constants ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_NOP = 4'b1111;
  - typedef enum state_t {IDLE, EXEC, RESP}.
- One sub-module, rr_arbiter: parameter N; inputs req[N-1:0], last[ID_W-1:0], en; outputs grant one-hot and grant index.
  - It is purely combinational.
  - The rr_last register lives in the top module.

Test Plan:
- Reset, then requester 0 sends a=5, b=3, op=0010 -> req_ready[0] in the accept cycle; alu_control=0010 for exactly 1 cycle; rsp_valid 2 cycles after accept with rsp_result=8, rsp_id=0, rsp_zero=0.
- Requester 1 SUB with a=7, b=7 -> rsp_result=0, rsp_zero=1. Then a=0, b=1 -> rsp_result=0xFFFFFFFF (wrap).
- Both requesters valid continuously with rsp_ready=1 -> grant order 0,1,0,1; one response every 2 cycles; ids match the grant order.
- rsp_ready held 0 for 5 cycles in RESP -> response fields stable, req_ready stays 0 and no new grant. When rsp_ready rises, the pending request is accepted in the same cycle.
- reset asserted during EXEC -> no rsp_valid afterwards; the next request is served with requester 0 having first priority.
- Opcode 0101 with ALU_SHARE_OPCHECK_EN defined -> rsp_err=1, rsp_result=0, alu_control=1111. Without the macro -> rsp_err=0 and rsp_result equals the ALU output of 0.
